switch_debounce_ctrl: RTL

- Front-end controller for the board slide-switch/push-button bank.
- Synchronises and debounces raw switch pins, then drives the clean vector to the switch PIO's `in_port`.
- Adds per-bit edge capture with selectable rising/falling detection, an interrupt mask and a level IRQ.
- Exposes these as a 4-word Avalon-MM slave in the SOPC system.

---
 rtl/switch_ctrl_pkg.sv | 18 +
 rtl/switch_debounce_bit.sv | 55 +++++
 rtl/switch_debounce_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/switch_ctrl_pkg.sv
// Shared constants for the switch debounce controller.
// Holds the Avalon register word offsets, the CTRL bit positions and the CTRL reset value.
package switch_ctrl_pkg;

   // Avalon word offsets
   localparam logic [1:0] REG_DATA = 2'd0;
   localparam logic [1:0] REG_MASK = 2'd1;
   localparam logic [1:0] REG_EDGE = 2'd2;
   localparam logic [1:0] REG_CTRL = 2'd3;

   // CTRL register bit positions
   localparam int unsigned CTRL_RISE = 0;
   localparam int unsigned CTRL_FALL = 1;

   // Rise and fall detection are both enabled out of reset
   localparam logic [1:0] CTRL_RESET = 2'b11;

endpackage

// File: rtl/switch_debounce_bit.sv
// Single-bit synchroniser and debouncer.
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   i_raw    - asynchronous raw switch pin
//   i_tick   - one-cycle sample strobe from the shared prescaler
//   o_stable - debounced level
// The pin passes through a 2-flop synchroniser. On each tick the synchronised level is shifted
// into a SAMPLES-deep history; the stable level only changes once every history entry agrees.
module switch_debounce_bit #(
   parameter int unsigned SAMPLES = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_raw,
   input  logic i_tick,
   output logic o_stable
);

   logic               r_sync1;
   logic               r_sync2;
   logic [SAMPLES-1:0] r_hist;
   logic               r_stable;

   logic [SAMPLES-1:0] w_hist_next;
   logic               w_all1;
   logic               w_all0;

   assign w_hist_next = {r_hist[SAMPLES-2:0], r_sync2};
   assign w_all1      = &w_hist_next;
   assign w_all0      = ~|w_hist_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_hist   <= '0;
         r_stable <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (i_tick) begin
            r_hist <= w_hist_next;
            if (w_all1) begin
               r_stable <= 1'b1;
            end else if (w_all0) begin
               r_stable <= 1'b0;
            end
         end
      end
   end

   assign o_stable = r_stable;

endmodule

// File: rtl/switch_debounce_ctrl.sv
// Switch bank front end: debounce, edge capture, interrupt and a 4-word Avalon-MM slave.
// Ports:
//   clk, reset_n          - system clock, asynchronous active-low reset
//   sw_raw                - asynchronous raw switch pins
//   address, chipselect,
//   read, write,
//   writedata, readdata   - Avalon-MM slave (readdata registered, 1-cycle read latency)
//   sw_stable             - debounced vector for the PIO in_port
//   irq                   - registered level interrupt, |(edge_capture & irq_mask)
// Registers: 0 DATA (R), 1 MASK (RW), 2 EDGE (R/W1C), 3 CTRL (RW, bit0 rise_en, bit1 fall_en).
module switch_debounce_ctrl
   import switch_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned TICK_DIV = 50000,
   parameter int unsigned SAMPLES  = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] sw_stable,
   output logic             irq
);

   localparam int unsigned PW = $clog2(TICK_DIV);

   logic [PW-1:0]    r_presc;
   logic [WIDTH-1:0] r_stable_d;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_edge;
   logic [1:0]       r_ctrl;
   logic [31:0]      r_readdata;
   logic             r_irq;

   logic             w_tick;
   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_hit;
   logic [WIDTH-1:0] w_clr;
   logic             w_wr;
   logic [31:0]      w_rdata;
   logic             w_unused_wdata;

   // Shared sample prescaler
   assign w_tick = (r_presc == PW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      switch_debounce_bit #(
         .SAMPLES(SAMPLES)
      ) u_bit (
         .clk     (clk),
         .reset_n (reset_n),
         .i_raw   (sw_raw[g]),
         .i_tick  (w_tick),
         .o_stable(w_stable[g])
      );
   end

   // Edge detection against the previous cycle's debounced vector
   assign w_rise = w_stable & ~r_stable_d;
   assign w_fall = ~w_stable & r_stable_d;
   assign w_hit  = (w_rise & {WIDTH{r_ctrl[CTRL_RISE]}}) |
                   (w_fall & {WIDTH{r_ctrl[CTRL_FALL]}});

   assign w_wr  = chipselect & write;
   assign w_clr = (w_wr && (address == REG_EDGE)) ? writedata[WIDTH-1:0] : '0;

   assign w_unused_wdata = ^writedata;

   // Read mux sees pre-write register state
   always_comb begin
      w_rdata = 32'd0;
      case (address)
         REG_DATA: w_rdata = 32'(w_stable);
         REG_MASK: w_rdata = 32'(r_mask);
         REG_EDGE: w_rdata = 32'(r_edge);
         default:  w_rdata = 32'(r_ctrl);
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stable_d <= '0;
         r_mask     <= '0;
         r_edge     <= '0;
         r_ctrl     <= CTRL_RESET;
         r_readdata <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_stable_d <= w_stable;
         // A new hit wins over a same-cycle W1C of that bit
         r_edge     <= (r_edge & ~w_clr) | w_hit;
         r_irq      <= |(r_edge & r_mask);
         if (w_wr && (address == REG_MASK)) begin
            r_mask <= writedata[WIDTH-1:0];
         end
         if (w_wr && (address == REG_CTRL)) begin
            r_ctrl <= writedata[1:0];
         end
         if (chipselect && read) begin
            r_readdata <= w_rdata;
         end
      end
   end

   assign sw_stable = w_stable;
   assign readdata  = r_readdata;
   assign irq       = r_irq;

endmodule
